serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning operands a, b and cin are offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept operands.
REQ-006 The block SHALL have ports a and b, inputs, WIDTH bits each, the unsigned operands.
REQ-007 The block SHALL have port cin, input, 1 bit, the carry-in.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning sum and cout are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-010 The block SHALL have port sum, output, WIDTH bits, equal to (a+b+cin) mod 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit, the final carry-out.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, on in_valid&&in_ready the block SHALL latch a, b and cin into shift and carry registers, clear the bit counter, and enter SHIFT.
REQ-015 In SHIFT, each cycle SHALL add one bit pair LSB-first with the carry register, shift the sum bit into the sum register from the MSB end, and update the carry register.
REQ-016 After exactly WIDTH SHIFT cycles (counter == WIDTH-1 on the last one) the FSM SHALL enter DONE; out_valid SHALL rise WIDTH+1 cycles after the accepting edge.
REQ-017 In DONE, sum and cout SHALL hold stable until out_ready is 1, and the FSM SHALL then return to IDLE on that edge.
REQ-018 in_valid while not in IDLE SHALL be ignored; out_ready while not in DONE SHALL be ignored.
REQ-019 A new operand set SHALL NOT be accepted in the same cycle that a result is consumed; there is one IDLE cycle minimum between results.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH, with the carry out of bit WIDTH-1 reported on cout; a=b=all-ones, cin=1 is legal.

Reset
REQ-021 When rst=1 at a clock edge, the FSM SHALL go to IDLE and the counter, shift registers, sum, cout and carry SHALL clear to 0; this gives in_ready=1 and out_valid=0 on the next cycle.
REQ-022 A reset asserted during SHIFT or DONE SHALL abort the operation with no result produced.
REQ-023 rst SHALL take priority over every handshake input in the same cycle.

Configuration
REQ-024 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add an output port ovf (1 bit) equal to the carry into bit WIDTH-1 XOR cout, valid with out_valid, and reset to 0.
REQ-025 Without SERIAL_ADDER_OVF_EN, port ovf and its register SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-026 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE), the default WIDTH constant, and the counter-width constant $clog2(32).
REQ-027 The per-bit addition SHALL be one instance of the team's single-bit full-adder cell; no other sub-modules are required.

Verification
REQ-028 The bench SHALL cover reset: rst=1 for 2 cycles -> in_ready=1, out_valid=0, sum=0, cout=0.
REQ-029 The bench SHALL cover a basic add: WIDTH=8, a=8'h35, b=8'h4A, cin=0 -> out_valid after 9 cycles, sum=8'h7F, cout=0.
REQ-030 The bench SHALL cover full-range carry: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1; with SERIAL_ADDER_OVF_EN, ovf=0.
REQ-031 The bench SHALL cover backpressure: out_ready=0 for 5 cycles after out_valid -> sum and cout stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
REQ-032 The bench SHALL cover mid-operation reset: rst=1 at the 4th SHIFT cycle -> IDLE next cycle and no out_valid; a following a=8'h01, b=8'h01 gives sum=8'h02.
REQ-033 The bench SHALL cover signed overflow (macro on): a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional overflow output is enabled with macro SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

   // Default operand/sum width.
   localparam int unsigned DEFAULT_WIDTH = 8;

   // Bit counter width, sized for the largest legal WIDTH (32).
   localparam int unsigned CNT_W = $clog2(32);

   // Control FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } stateT;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell; purely combinational.
module serial_adder_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s_c,
   output logic co_c
);

   // Sum and carry of one bit position.
   always_comb begin
      s_c  = a ^ b ^ ci;
      co_c = (a & b) | (ci & (a ^ b));
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts a, b, cin via valid/ready, adds one bit per cycle
// LSB-first, then presents sum/cout until the consumer takes them.
// Optional signed-overflow output ovf is enabled with macro SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   stateT            state;
   stateT            nextState;
   logic [CNT_W-1:0] bitCnt;
   logic [WIDTH-1:0] aShift;
   logic [WIDTH-1:0] bShift;
   logic             carry;
   logic             accept_c;
   logic             lastBit_c;
   logic             sumBit_c;
   logic             carryOut_c;

   // One full-adder cell works on the current LSB pair and the running carry.
   serial_adder_fa uFa (
      .a    (aShift[0]),
      .b    (bShift[0]),
      .ci   (carry),
      .s_c  (sumBit_c),
      .co_c (carryOut_c)
   );

   // Next-state logic and datapath strobes.
   always_comb begin
      nextState = state;
      accept_c  = 1'b0;
      lastBit_c = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept_c  = 1'b1;
               nextState = SHIFT;
            end
         end
         SHIFT: begin
            if (bitCnt == CNT_W'(WIDTH - 1)) begin
               lastBit_c = 1'b1;
               nextState = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Handshake flags registered from the upcoming state so they track it exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= (nextState == IDLE);
         out_valid <= (nextState == DONE);
      end
   end

   // Operand load, per-bit shift/accumulate, and final carry capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         aShift <= '0;
         bShift <= '0;
         sum    <= '0;
         carry  <= 1'b0;
         cout   <= 1'b0;
         bitCnt <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf    <= 1'b0;
`endif
      end else if (accept_c) begin
         aShift <= a;
         bShift <= b;
         carry  <= cin;
         bitCnt <= '0;
      end else if (state == SHIFT) begin
         aShift <= aShift >> 1;
         bShift <= bShift >> 1;
         sum    <= {sumBit_c, sum[WIDTH-1:1]};
         carry  <= carryOut_c;
         bitCnt <= bitCnt + CNT_W'(1);
         if (lastBit_c) begin
            cout <= carryOut_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on the last bit
            ovf  <= carry ^ carryOut_c;
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random
// operands compared against an arithmetic reference. Checks ovf only when
// SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int nChecks = 0;
   int nPass   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nChecks++;
      assert (obs === expv) nPass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Reference: plain (W+1)-bit addition gives {cout, sum}.
   function automatic logic [W:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
   endfunction

`ifdef SERIAL_ADDER_OVF_EN
   // Reference: two's-complement overflow of x + y + c.
   function automatic logic refOvf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W-1:0] s;
      s = x + y + W'(c);
      return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
   endfunction
`endif

   // One full transaction: offer, wait for result, optionally stall, consume.
   task automatic runOp(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input int hold, input logic early, input string tag);
      logic [W:0] expSum;
      int         edges;
      expSum = refAdd(x, y, c);
      @(negedge clk);
      check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
      a         = x;
      b         = y;
      cin       = c;
      in_valid  = 1'b1;
      out_ready = early;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check({tag, ".latency"}, 32'(edges), 32'(W + 1));
      check({tag, ".sum"}, 32'(sum), 32'(expSum[W-1:0]));
      check({tag, ".cout"}, 32'(cout), 32'(expSum[W]));
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, ".ovf"}, 32'(ovf), 32'(refOvf(x, y, c)));
`endif
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         in_valid  = 1'($urandom);
         a         = W'($urandom);
         b         = W'($urandom);
         @(posedge clk);
         @(negedge clk);
         check({tag, ".hold_sum"}, 32'(sum), 32'(expSum[W-1:0]));
         check({tag, ".hold_cout"}, 32'(cout), 32'(expSum[W]));
         check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
         check({tag, ".hold_out_valid"}, 32'(out_valid), 32'd1);
      end
      // Offer junk in the consume cycle; it must not be taken.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, ".post_out_valid"}, 32'(out_valid), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      logic seen;
      // Reset with handshake inputs active: reset must win.
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = 8'hA5;
      b         = 8'h5A;
      cin       = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("reset.in_ready", 32'(in_ready), 32'd1);
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.sum", 32'(sum), 32'd0);
      check("reset.cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("reset.ovf", 32'(ovf), 32'd0);
`endif

      runOp(8'h35, 8'h4A, 1'b0, 0, 1'b0, "basic");
      runOp(8'hFF, 8'hFF, 1'b1, 0, 1'b1, "fullcarry");
      runOp(8'hC3, 8'h9E, 1'b1, 5, 1'b0, "backpressure");
      runOp(8'h7F, 8'h01, 1'b0, 1, 1'b0, "signed_ovf");

      // Abort in the 4th SHIFT cycle.
      @(negedge clk);
      a        = 8'h10;
      b        = 8'h20;
      cin      = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midreset.in_ready", 32'(in_ready), 32'd1);
      check("midreset.out_valid", 32'(out_valid), 32'd0);
      check("midreset.sum", 32'(sum), 32'd0);
      check("midreset.cout", 32'(cout), 32'd0);
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("midreset.no_result", 32'(seen), 32'd0);
      out_ready = 1'b0;
      runOp(8'h01, 8'h01, 1'b0, 0, 1'b0, "after_reset");

      // Random operands, stall lengths and early-ready behaviour.
      for (int k = 0; k < 20; k++) begin
         runOp(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
               1'($urandom), "random");
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
